nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder built on the existing 4-bit ripple adder (fourBitAdder); one instance is reused once per nibble.
- Accepts WIDTH-bit operands over a valid/ready handshake and feeds one nibble per cycle, LSB first, into the 4-bit adder.
- Carries the adder's carry-out between cycles in a register and assembles the WIDTH-bit sum and final carry.
- Sits directly around the 4-bit adder: supplies its operands and carry-in, and consumes its sum and carry-out.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- NIB, WIDTH/4, derived nibble count and number of adder passes; not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present on a, b, cin.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into nibble 0.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, a+b+cin mod 2^WIDTH.
- cout  output  1  carry out of the MSB nibble.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, and has priority over all other inputs. On rst: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, carry reg=0, nibble counter=0.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch a and b into shift regs and cin into the carry reg; clear counter; go to RUN.
- State RUN:
  - in_ready=0, out_valid=0.
  - Each cycle the adder sees the low nibbles of the A/B shift regs plus the carry reg.
  - On the edge: the nibble sum is shifted into the top of the result reg (result shifts right 4); the carry reg takes the adder's cout; A/B shift right 4; counter increments.
  - When counter reaches NIB-1 and that pass completes: go to DONE; sum=result reg; cout=carry reg.
- State DONE:
  - out_valid=1, in_ready=0. sum and cout are held stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE. out_valid deasserts on the next cycle; in_ready=1 on the next cycle.
- Latency: acceptance edge E; out_valid is high after edge E+NIB (WIDTH=16: 4 cycles; WIDTH=4: 1 cycle).
- Throughput: one transaction per NIB+2 cycles minimum. Input and output handshakes never overlap.
- in_valid during RUN or DONE is ignored; operands are not queued. a, b and cin need only be stable in the acceptance cycle.
- out_ready outside DONE has no effect.
- Wrap: sum is modulo 2^WIDTH; the overflowed bit appears only on cout.
- rst mid-RUN or in DONE: the transaction is discarded; next cycle is IDLE with reset values; no out_valid pulse for it.
- sum and cout retain their last value in IDLE and RUN; consumers must qualify with out_valid.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_OVERFLOW_EN.
- Defined: extra output port ovf (1 bit, reset 0) is added.
  - At acceptance, the operand MSBs a[WIDTH-1] and b[WIDTH-1] are latched.
  - Entering DONE: ovf=(a_msb==b_msb)&&(sum[WIDTH-1]!=a_msb), the two's-complement signed overflow.
  - ovf is held with sum.
- Undefined: no ovf port and no MSB registers; all other behaviour is identical.

Test Plan:
- Reset: rst high 2 cycles with random inputs -> in_ready=1, out_valid=0, sum=16'h0000, cout=0.
- a=16'h1234, b=16'h4321, cin=0, out_ready=1 -> out_valid exactly 4 cycles after acceptance, sum=16'h5555, cout=0; in_ready low during RUN and DONE.
- a=16'hFFFF, b=16'h0001, cin=0 (carry through all nibbles), then a=16'hFFFF, b=16'hFFFF, cin=1 -> first sum=16'h0000, cout=1; second sum=16'hFFFF, cout=1.
- Backpressure: a=16'h00F0, b=16'h0010, cin=1, out_ready=0 for 6 cycles, with in_valid held high using new operands -> sum=16'h0101 held stable, new operands not accepted; out_ready=1 -> IDLE next cycle, then the new operands are accepted.
- Reset mid-operation: rst asserted in the 2nd RUN cycle -> next cycle IDLE, in_ready=1, no out_valid for the aborted transaction; next transaction 16'h0003+16'h0004 -> 16'h0007.
- With NIBBLE_SERIAL_ADDER_OVERFLOW_EN: 16'h7FFF+16'h0001 -> sum=16'h8000, cout=0, ovf=1; 16'h8000+16'h8000 -> sum=16'h0000, cout=1, ovf=1; 16'hFFFF+16'h0001 -> ovf=0.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit ripple adder once per nibble, LSB first.
// Optional signed-overflow flag output ovf when NIBBLE_SERIAL_ADDER_OVERFLOW_EN is defined.

module fourBitAdder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic c;

  always_comb begin
    c   = cin;
    sum = 4'h0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               ovf_q, ovf_d;
`endif

  logic [3:0]         add_sum;
  logic               add_co;
  logic [WIDTH-1:0]   res_next;
  logic               last_pass;

  fourBitAdder u_add (
    .a    (a_sh_q[3:0]),
    .b    (b_sh_q[3:0]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_co)
  );

  // Each nibble sum enters at the top so after NIB passes nibble 0 sits at the bottom.
  assign res_next  = (res_q >> 4) | (WIDTH'(add_sum) << (WIDTH - 4));
  assign last_pass = (cnt_q == CNT_W'(NIB - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)             state_d = RUN;
      RUN:     if (last_pass)            state_d = DONE;
      DONE:    if (out_ready)            state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        res_d   = res_next;
        carry_d = add_co;
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_pass) begin
          sum_d  = res_next;
          cout_d = add_co;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
          ovf_d  = (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
`endif
        end
      end
      default: ;
    endcase
  end

  // Control and visible results are reset; operand shift regs need no reset.
  always_ff @(posedge clk) begin
    a_sh_q <= a_sh_d;
    b_sh_q <= b_sh_d;
    res_q  <= res_d;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    a_msb_q <= a_msb_d;
    b_msb_q <= b_msb_d;
`endif
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16); also checks ovf when NIBBLE_SERIAL_ADDER_OVERFLOW_EN is defined.

module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  logic             ovf;
`endif

  int n_chk = 0;
  int n_err = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands in IDLE and take the acceptance edge.
  task automatic accept(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Called right after the acceptance edge: RUN for NIB cycles, then DONE.
  task automatic await_done(input string tag, input logic [WIDTH-1:0] exp_sum,
                            input logic exp_cout, input logic exp_ovf);
    for (int i = 0; i < NIB; i++) begin
      chk({tag, "_run_vld"}, 32'(out_valid), 32'd0);
      chk({tag, "_run_rdy"}, 32'(in_ready), 32'd0);
      step();
    end
    chk({tag, "_vld"},  32'(out_valid), 32'd1);
    chk({tag, "_rdy"},  32'(in_ready), 32'd0);
    chk({tag, "_sum"},  32'(sum), 32'(exp_sum));
    chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    chk({tag, "_ovf"},  32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) chk({tag, "_ovf_arg"}, 32'(exp_ovf), 32'd0);
`endif
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    chk({tag, "_idle_vld"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
  endtask

  task automatic txn(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                     input logic cv, input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                     input logic exp_ovf);
    out_ready = 1'b1;
    accept(av, bv, cv);
    await_done(tag, exp_sum, exp_cout, exp_ovf);
    release_out(tag);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'($urandom);
    a         = WIDTH'($urandom);
    b         = WIDTH'($urandom);
    cin       = 1'($urandom);
    out_ready = 1'($urandom);
    step();
    in_valid  = 1'($urandom);
    a         = WIDTH'($urandom);
    out_ready = 1'($urandom);
    step();
    chk("rst_in_ready",  32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",       32'(sum), 32'h0000);
    chk("rst_cout",      32'(cout), 32'd0);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    txn("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    txn("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    txn("all_one", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // Backpressure: result held while new operands wait on in_valid.
    out_ready = 1'b0;
    accept(16'h00F0, 16'h0010, 1'b1);
    await_done("bp", 16'h0101, 1'b0, 1'b0);
    a        = 16'h0011;
    b        = 16'h0022;
    cin      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp_hold_vld", 32'(out_valid), 32'd1);
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
      chk("bp_hold_sum", 32'(sum), 32'h0101);
    end
    out_ready = 1'b1;
    step();
    chk("bp_idle_vld", 32'(out_valid), 32'd0);
    chk("bp_idle_rdy", 32'(in_ready), 32'd1);
    chk("bp_idle_sum", 32'(sum), 32'h0101);
    step();
    in_valid = 1'b0;
    await_done("bp_next", 16'h0033, 1'b0, 1'b0);
    release_out("bp_next");

    // Abort in the second RUN cycle.
    accept(16'h0005, 16'h0006, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_rdy", 32'(in_ready), 32'd1);
    chk("abort_vld", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'h0000);
    for (int i = 0; i < NIB + 2; i++) begin
      step();
      chk("abort_no_vld", 32'(out_valid), 32'd0);
    end
    txn("after_abort", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    txn("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    txn("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    txn("ovf_no",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
